// File: rtl/spi_pkg.sv
// Shared constants for the SPI ADC master and the blocks that consume its frames.
package spi_pkg;

   localparam int DW_ADC         = 13;
   localparam int LOG2_N_DEFAULT = 3;
   localparam int SYS_CLK_HZ     = 16_000_000;
   localparam int CW_DEFAULT     = 16;

endpackage

// File: rtl/spi_sample_avg_if.sv
// Signal bundle between the SPI averager and whoever drives and observes it.
interface spi_sample_avg_if
   import spi_pkg::*;
#(
   parameter int DW = DW_ADC,
   parameter int CW = CW_DEFAULT
);

   logic          nCS;
   logic [DW-1:0] din;
   logic          clr;
   logic [DW-1:0] thr;
   logic [DW-1:0] raw;
   logic [DW-1:0] avg;
   logic          avg_valid;
   logic          primed;
   logic          alarm;
   logic [CW-1:0] sample_cnt;

   modport master (
      output nCS, din, clr, thr,
      input  raw, avg, avg_valid, primed, alarm, sample_cnt
   );

   modport slave (
      input  nCS, din, clr, thr,
      output raw, avg, avg_valid, primed, alarm, sample_cnt
   );

endinterface

// File: rtl/spi_frame_detect.sv
// End-of-frame detector: flags the cycle where nCS rises, unless a clear is pending.
module spi_frame_detect (
   input  logic clk,
   input  logic rst,
   input  logic nCS,
   input  logic clr,
   output logic cap
);

   logic nCS_q;

   // Resetting to 1 means an nCS that is already high after reset is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nCS_q <= 1'b1;
      end else begin
         nCS_q <= nCS;
      end
   end

   assign cap = nCS & ~nCS_q & ~clr;

endmodule

// File: rtl/spi_sample_avg.sv
// Moving-average consumer of the SPI ADC master: one sample per frame, registered
// window average, one-cycle valid strobe and a threshold alarm.
module spi_sample_avg
   import spi_pkg::*;
#(
   parameter int DW     = DW_ADC,
   parameter int LOG2_N = LOG2_N_DEFAULT,
   parameter int CW     = CW_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   spi_sample_avg_if.slave bus
);

   localparam int              SW   = DW + LOG2_N;
   localparam int              N    = 1 << LOG2_N;
   localparam logic [LOG2_N:0] FULL = (LOG2_N + 1)'(N);

   logic              cap;
   logic [DW-1:0]     win [N];
   logic [LOG2_N-1:0] wp;
   logic [SW-1:0]     sum;
   logic [LOG2_N:0]   fill;
   logic [CW-1:0]     cnt;
   logic [DW-1:0]     rawQ;
   logic              updQ;
   logic              primed;
   logic [DW-1:0]     avgNext;
   logic [DW-1:0]     avgQ;
   logic              alarmQ;
   logic              validQ;

   spi_frame_detect u_detect (
      .clk (clk),
      .rst (rst),
      .nCS (bus.nCS),
      .clr (bus.clr),
      .cap (cap)
   );

   assign primed  = (fill == FULL);
   assign avgNext = sum[SW-1:LOG2_N];

   // Capture stage: the window starts zero-filled, so the running sum never exceeds SW bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rawQ <= '0;
         wp   <= '0;
         sum  <= '0;
         fill <= '0;
         cnt  <= '0;
         updQ <= 1'b0;
         for (int i = 0; i < N; i++) win[i] <= '0;
      end else if (bus.clr) begin
         wp   <= '0;
         sum  <= '0;
         fill <= '0;
         cnt  <= '0;
         updQ <= 1'b0;
         for (int i = 0; i < N; i++) win[i] <= '0;
      end else begin
         updQ <= cap;
         if (cap) begin
            rawQ    <= bus.din;
            win[wp] <= bus.din;
            sum     <= sum + SW'(bus.din) - SW'(win[wp]);
            wp      <= wp + LOG2_N'(1);
            cnt     <= cnt + CW'(1);
            if (fill != FULL) fill <= fill + (LOG2_N + 1)'(1);
         end
      end
   end

   // Result stage: publish only once the window holds a full set of real samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         avgQ   <= '0;
         alarmQ <= 1'b0;
         validQ <= 1'b0;
      end else if (bus.clr) begin
         avgQ   <= '0;
         alarmQ <= 1'b0;
         validQ <= 1'b0;
      end else begin
         validQ <= updQ & primed;
         if (updQ && primed) begin
            avgQ   <= avgNext;
            alarmQ <= (avgNext > bus.thr);
         end
      end
   end

   assign bus.raw        = rawQ;
   assign bus.avg        = avgQ;
   assign bus.alarm      = alarmQ;
   assign bus.avg_valid  = validQ;
   assign bus.primed     = primed;
   assign bus.sample_cnt = cnt;

endmodule

// File: tb/tb_spi_sample_avg.sv
// Self-checking bench for spi_sample_avg: table-driven ramp plus hand-written
// sequences, with a scoreboard that matches every avg_valid pulse to a predicted result.
`timescale 1ns/1ps
module tb_spi_sample_avg;
   import spi_pkg::*;

   localparam int DW     = 13;
   localparam int LOG2_N = 3;
   localparam int CW     = 16;
   localparam int N      = 8;

   typedef struct {
      int unsigned avg;
      bit          alarm;
   } exp_t;

   typedef struct {
      logic [DW-1:0] din;
      logic [DW-1:0] thr;
      int unsigned   expAvg;
      bit            expAlarm;
      bit            expPrimed;
      int unsigned   expCnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   spi_sample_avg_if #(.DW(DW), .CW(CW)) bus ();

   spi_sample_avg #(.DW(DW), .LOG2_N(LOG2_N), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int passCount  = 0;
   int pulseCount = 0;
   int expectedPulses = 0;

   exp_t expQ[$];

   int unsigned mdlWin[N];
   int unsigned mdlSum;
   int          mdlWp;
   int          mdlFill;
   int unsigned mdlCnt;

   vec_t vecs[16];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic mdlClear();
      for (int i = 0; i < N; i++) mdlWin[i] = 0;
      mdlSum  = 0;
      mdlWp   = 0;
      mdlFill = 0;
      mdlCnt  = 0;
      expectedPulses -= expQ.size();
      expQ.delete();
   endtask

   task automatic modelCapture(input int unsigned value, input int unsigned thr);
      exp_t e;
      mdlSum = mdlSum + value - mdlWin[mdlWp];
      mdlWin[mdlWp] = value;
      mdlWp  = (mdlWp + 1) % N;
      mdlCnt = (mdlCnt + 1) % (1 << CW);
      if (mdlFill < N) mdlFill++;
      if (mdlFill == N) begin
         e.avg   = mdlSum / N;
         e.alarm = (e.avg > thr);
         expQ.push_back(e);
         expectedPulses++;
      end
   endtask

   // One SPI frame: nCS low for lowCycles, then high for highCycles with din valid.
   task automatic applyStimulus(input logic [DW-1:0] value, input int lowCycles, input int highCycles);
      @(posedge clk); #1;
      bus.nCS = 1'b0;
      bus.din = value;
      repeat (lowCycles - 1) @(posedge clk);
      @(posedge clk); #1;
      bus.nCS = 1'b1;
      modelCapture(value, bus.thr);
      repeat (highCycles - 1) @(posedge clk);
   endtask

   task automatic doClear();
      @(posedge clk); #1;
      bus.clr = 1'b1;
      mdlClear();
      @(posedge clk); #1;
      bus.clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst && bus.avg_valid) begin
         pulseCount++;
         if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_avg_valid at %0t: got avg=%0d, expected no pulse", $time, bus.avg);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sb_avg", 32'(bus.avg), e.avg);
            checkOutput("sb_alarm", 32'(bus.alarm), 32'(e.alarm));
         end
      end
   end

   initial begin
      int pulsesBefore;

      for (int k = 1; k <= 16; k++) begin
         vecs[k-1].din       = DW'(k - 1);
         vecs[k-1].thr       = DW'(5);
         vecs[k-1].expPrimed = (k >= 8);
         vecs[k-1].expCnt    = k;
         vecs[k-1].expAvg    = (k >= 8) ? (2 * k - 9) / 2 : 0;
         vecs[k-1].expAlarm  = (vecs[k-1].expAvg > 5);
      end

      bus.nCS = 1'b1;
      bus.din = '0;
      bus.clr = 1'b0;
      bus.thr = DW'(150);
      mdlClear();

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_raw", 32'(bus.raw), 0);
      checkOutput("reset_avg", 32'(bus.avg), 0);
      checkOutput("reset_valid", 32'(bus.avg_valid), 0);
      checkOutput("reset_primed", 32'(bus.primed), 0);
      checkOutput("reset_alarm", 32'(bus.alarm), 0);
      checkOutput("reset_cnt", 32'(bus.sample_cnt), 0);
      rst = 1'b1;

      $display("[TB] eight frames of 100");
      for (int i = 0; i < 7; i++) applyStimulus(DW'(100), 2, 4);
      checkOutput("pre_prime_primed", 32'(bus.primed), 0);
      @(posedge clk); #1;
      bus.nCS = 1'b0;
      @(posedge clk); #1;
      bus.nCS = 1'b1;
      modelCapture(100, bus.thr);
      @(negedge clk);
      @(negedge clk);
      checkOutput("lat_e1_valid", 32'(bus.avg_valid), 0);
      @(negedge clk);
      checkOutput("lat_e2_valid", 32'(bus.avg_valid), 1);
      @(negedge clk);
      checkOutput("lat_e3_valid", 32'(bus.avg_valid), 0);
      checkOutput("prime_avg", 32'(bus.avg), 100);
      checkOutput("prime_primed", 32'(bus.primed), 1);
      checkOutput("prime_cnt", 32'(bus.sample_cnt), 8);
      checkOutput("prime_alarm", 32'(bus.alarm), 0);

      $display("[TB] step to 900 with threshold 150");
      applyStimulus(DW'(900), 2, 4);
      @(negedge clk);
      checkOutput("step_avg", 32'(bus.avg), 200);
      checkOutput("step_alarm", 32'(bus.alarm), 1);
      checkOutput("step_raw", 32'(bus.raw), 900);

      $display("[TB] ramp 0..15 after clear");
      doClear();
      @(negedge clk);
      checkOutput("clr_avg", 32'(bus.avg), 0);
      checkOutput("clr_alarm", 32'(bus.alarm), 0);
      checkOutput("clr_raw_kept", 32'(bus.raw), 900);
      for (int i = 0; i < 16; i++) begin
         bus.thr = vecs[i].thr;
         applyStimulus(vecs[i].din, 2, 4);
         @(negedge clk);
         checkOutput($sformatf("ramp%0d_avg", i + 1), 32'(bus.avg), vecs[i].expAvg);
         checkOutput($sformatf("ramp%0d_alarm", i + 1), 32'(bus.alarm), 32'(vecs[i].expAlarm));
         checkOutput($sformatf("ramp%0d_primed", i + 1), 32'(bus.primed), 32'(vecs[i].expPrimed));
         checkOutput($sformatf("ramp%0d_cnt", i + 1), 32'(bus.sample_cnt), vecs[i].expCnt);
      end

      $display("[TB] full-scale window");
      doClear();
      bus.thr = DW'(8000);
      for (int i = 0; i < 8; i++) applyStimulus(DW'(8191), 2, 4);
      @(negedge clk);
      checkOutput("fullscale_avg", 32'(bus.avg), 8191);
      checkOutput("fullscale_alarm", 32'(bus.alarm), 1);

      $display("[TB] clear coincident with frame end");
      @(posedge clk); #1;
      bus.nCS = 1'b0;
      bus.din = DW'(55);
      @(posedge clk); #1;
      bus.nCS = 1'b1;
      bus.clr = 1'b1;
      mdlClear();
      @(posedge clk); #1;
      bus.clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("coinc_cnt", 32'(bus.sample_cnt), 0);
      checkOutput("coinc_primed", 32'(bus.primed), 0);
      checkOutput("coinc_raw", 32'(bus.raw), 8191);
      checkOutput("coinc_avg", 32'(bus.avg), 0);
      pulsesBefore = pulseCount;
      for (int i = 0; i < 7; i++) applyStimulus(DW'(10), 2, 2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("coinc7_primed", 32'(bus.primed), 0);
      checkOutput("coinc7_cnt", 32'(bus.sample_cnt), 7);
      checkOutput("coinc7_pulses", 32'(pulseCount - pulsesBefore), 0);

      $display("[TB] back-to-back frames");
      doClear();
      bus.thr = DW'(400);
      pulsesBefore = pulseCount;
      for (int i = 0; i < 10; i++) applyStimulus(DW'(i * 97 + 13), 1, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("b2b_cnt", 32'(bus.sample_cnt), 10);
      checkOutput("b2b_pulses", 32'(pulseCount - pulsesBefore), 3);

      $display("[TB] asynchronous reset mid-stream");
      for (int i = 0; i < 3; i++) applyStimulus(DW'(77), 2, 4);
      @(posedge clk); #1;
      bus.nCS = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      bus.nCS = 1'b1;
      #1;
      checkOutput("arst_raw", 32'(bus.raw), 0);
      checkOutput("arst_avg", 32'(bus.avg), 0);
      checkOutput("arst_valid", 32'(bus.avg_valid), 0);
      checkOutput("arst_primed", 32'(bus.primed), 0);
      checkOutput("arst_alarm", 32'(bus.alarm), 0);
      checkOutput("arst_cnt", 32'(bus.sample_cnt), 0);
      mdlClear();
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("post_rst_cnt", 32'(bus.sample_cnt), 0);
      checkOutput("post_rst_raw", 32'(bus.raw), 0);
      bus.thr = DW'(10);
      for (int i = 0; i < 8; i++) applyStimulus(DW'(20), 2, 4);
      @(negedge clk);
      checkOutput("post_rst_avg", 32'(bus.avg), 20);
      checkOutput("post_rst_alarm", 32'(bus.alarm), 1);
      checkOutput("post_rst_primed", 32'(bus.primed), 1);

      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("sb_drained", 32'(expQ.size()), 0);
      checkOutput("pulse_total", 32'(pulseCount), 32'(expectedPulses));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
